wavetable_additive_synth: RTL and testbench
===========================================

Name: wavetable_additive_synth

Overview:
Parametrised additive wavetable oscillator. Generates NUM_HARM harmonics (k·freq, k=1..NUM_HARM) of one fundamental from a single shared sine ROM. Harmonics are time-multiplexed over a one-cycle-per-harmonic pipeline and weighted by per-harmonic gains. The saturated sum feeds the sample mixer once per sample_Clk strobe, replacing one fixed-harmonic oscillator per harmonic.

Parameters:
PHASE_W, 24, phase accumulator / freq width
ADDR_W, 12, ROM address width; address = phase[PHASE_W-1 -: ADDR_W]
DATA_W, 16, signed ROM sample and output width
NUM_HARM, 8, harmonic count (1..16)
GAIN_W, 8, unsigned per-harmonic gain width; gain/2^GAIN_W = weight
TABLE_FILE, "sine.hex", $readmemh image, 2^ADDR_W signed entries

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
CS  in  1  enable; low = synchronous clear, output forced 0
sample_Clk  in  1  one-Clk-wide sample strobe
freq  in  PHASE_W  fundamental phase increment per sample
gain  in  NUM_HARM*GAIN_W  gain[h] = bits [h*GAIN_W +: GAIN_W], h=0 is fundamental
out  out  DATA_W  signed mixed sample, held between updates
out_valid  out  1  one-cycle pulse when out updates
busy  out  1  high from strobe acceptance until out_valid cycle inclusive
overrun  out  1  sticky: strobe arrived while busy

Behaviour:
- Reset_n low (async): out=0, out_valid=0, busy=0, overrun=0, all phase[h]=0, accumulator=0, FSM=IDLE.
- CS low (sync, highest priority after reset): same clear as reset; strobes ignored. CS low mid-run aborts, no out_valid.
- FSM: IDLE -> RUN on sample_Clk&CS; RUN lasts NUM_HARM cycles (h=0..NUM_HARM-1, one per cycle) -> DRAIN (2 cycles) -> DONE (1 cycle, out_valid=1) -> IDLE.
- freq and gain latched at strobe acceptance; changes mid-run have no effect on that sample.
- Increment: inc_0=freq_latched; inc_h=inc_(h-1)+freq_latched (adder chain, no multiplier), mod 2^PHASE_W.
- RUN cycle h: ROM address from current phase[h]; phase[h] <= phase[h]+inc_h (wraps mod 2^PHASE_W). First sample after reset reads address 0.
- Pipeline: address -> ROM registered read (1 cycle) -> product = signed sample × {0,gain[h]} accumulated into ACC_W = DATA_W+GAIN_W+clog2(NUM_HARM)+1 bits; accumulator cleared at strobe acceptance.
- DONE: out <= saturate(acc >>> GAIN_W) to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; arithmetic shift (floor).
- Latency: strobe sampled in cycle t -> out_valid in cycle t+NUM_HARM+4; busy high cycles t+1..t+NUM_HARM+4.
- Strobe while busy (including DONE cycle): ignored, overrun<=1; cleared only by reset or CS low.
- Gain 0 harmonic still advances its phase.

Optional Feature:
NYQUIST_MUTE_EN: when defined, harmonic h with inc_h >= 2^(PHASE_W-1) (or inc_h wrapped, i.e. true (h+1)·freq >= 2^(PHASE_W-1)) contributes 0 to the accumulator; its phase still advances. When undefined, all harmonics contribute regardless (aliasing permitted).

Test Plan:
Ramp table (entry a = a), gain[0]=0x80 others 0, freq=0x001000, 5 strobes -> out = 0,0,1,1,2; each out_valid exactly NUM_HARM+4=12 cycles after its strobe.
Ramp table, gain[0]=0x80, freq=0xFFF000 -> addresses 0,4095,4094 -> out = 0,2047,2047 (phase wrap).
Constant table 0x7FFF, all gains 0xFF -> out=0x7FFF; constant 0x8000 -> out=0x8000 (saturation both rails).
Second strobe 3 cycles after first -> ignored, overrun=1, single out_valid at +12, busy deasserts at +13.
CS low at cycle 5 of RUN -> no out_valid, out=0, next strobe after CS high reads address 0 for all harmonics; Reset_n low mid-run asserts clear asynchronously.
With NYQUIST_MUTE_EN, ramp table, freq=0x400000, gain[0]=gain[1]=0x80 others 0 -> only h=0 contributes (h=1 increment 0x800000 muted); without macro, both contribute.

Source files
------------

// File: rtl/wavetable_additive_synth.sv
// rtl/wavetable_additive_synth.sv - additive wavetable oscillator, NUM_HARM harmonics time-multiplexed over one sine ROM
// Optional feature: define NYQUIST_MUTE_EN to silence harmonics whose true increment reaches half the phase range.
module wavetable_additive_synth #(
  parameter int PHASE_W    = 24,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 16,
  parameter int NUM_HARM   = 8,
  parameter int GAIN_W     = 8,
  parameter     TABLE_FILE = "sine.hex",
  parameter bit LOAD_TABLE = 1'b1
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         CS,
  input  logic                         sample_Clk,
  input  logic [PHASE_W-1:0]           freq,
  input  logic [NUM_HARM*GAIN_W-1:0]   gain,
  output logic signed [DATA_W-1:0]     out,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         overrun
);
  localparam int HW     = (NUM_HARM > 1) ? $clog2(NUM_HARM) : 1;
  localparam int ACC_W  = DATA_W + GAIN_W + $clog2(NUM_HARM) + 1;
  localparam int PROD_W = DATA_W + GAIN_W + 1;
`ifdef NYQUIST_MUTE_EN
  localparam int INC_W  = PHASE_W + $clog2(NUM_HARM) + 1;
`else
  localparam int INC_W  = PHASE_W;
`endif
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI - ACC_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN0, S_DRAIN1, S_DONE} state_t;

  state_t                       state, state_nxt;
  logic [HW-1:0]                hcnt;
  logic [PHASE_W-1:0]           freq_l;
  logic [NUM_HARM*GAIN_W-1:0]   gain_l;
  logic [INC_W-1:0]             inc;
  logic [PHASE_W-1:0]           phase [NUM_HARM];
  logic signed [DATA_W-1:0]     rom [0:(1<<ADDR_W)-1];
  logic signed [DATA_W-1:0]     rom_q;
  logic [ADDR_W-1:0]            rd_addr;
  logic                         v1, m1, v2, mute_now, strobe_ok, last_h;
  logic [HW-1:0]                h1;
  logic [GAIN_W-1:0]            g_sel;
  logic signed [PROD_W-1:0]     samp_x, gain_x, prod_d, prod_q;
  logic signed [ACC_W-1:0]      acc, acc_sh;
  logic signed [DATA_W-1:0]     sat_out;

  generate
    if (LOAD_TABLE) begin : g_rom_init
      initial begin
        for (int a = 0; a < (1 << ADDR_W); a++) begin
          rom[a] = DATA_W'($rtoi($sin(2.0 * 3.141592653589793 * a / (1 << ADDR_W))
                                 * ((2.0 ** (DATA_W - 1)) - 1.0)));
        end
      end
    end
  endgenerate

  assign busy      = (state != S_IDLE) || out_valid;
  assign strobe_ok = CS && sample_Clk && !busy;
  assign last_h    = (hcnt == HW'(NUM_HARM-1));
  assign rd_addr   = phase[hcnt][PHASE_W-1 -: ADDR_W];

`ifdef NYQUIST_MUTE_EN
  // inc carries the unwrapped (h+1)*freq so wrapped increments are caught too
  assign mute_now = (inc >= (INC_W'(1) << (PHASE_W-1)));
`else
  assign mute_now = 1'b0;
`endif

  always_comb begin
    g_sel   = gain_l[h1*GAIN_W +: GAIN_W];
    samp_x  = PROD_W'(rom_q);
    gain_x  = $signed(PROD_W'({1'b0, g_sel}));
    prod_d  = samp_x * gain_x;
    acc_sh  = acc >>> GAIN_W;
    sat_out = acc_sh[DATA_W-1:0];
    if (acc_sh > SAT_HI) sat_out = SAT_HI[DATA_W-1:0];
    else if (acc_sh < SAT_LO) sat_out = SAT_LO[DATA_W-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (strobe_ok) state_nxt = S_RUN;
      S_RUN:    if (last_h) state_nxt = S_DRAIN0;
      S_DRAIN0: state_nxt = S_DRAIN1;
      S_DRAIN1: state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (!CS) state_nxt = S_IDLE;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge Clk) begin
    rom_q <= rom[rd_addr];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hcnt <= '0; freq_l <= '0; gain_l <= '0; inc <= '0;
      v1 <= 1'b0; m1 <= 1'b0; h1 <= '0; v2 <= 1'b0; prod_q <= '0; acc <= '0;
      out <= '0; out_valid <= 1'b0; overrun <= 1'b0;
      for (int i = 0; i < NUM_HARM; i++) phase[i] <= '0;
    end else if (!CS) begin
      hcnt <= '0; freq_l <= '0; gain_l <= '0; inc <= '0;
      v1 <= 1'b0; m1 <= 1'b0; h1 <= '0; v2 <= 1'b0; prod_q <= '0; acc <= '0;
      out <= '0; out_valid <= 1'b0; overrun <= 1'b0;
      for (int i = 0; i < NUM_HARM; i++) phase[i] <= '0;
    end else begin
      out_valid <= (state == S_DONE);
      if (sample_Clk && busy) overrun <= 1'b1;
      // stage 1: ROM word in flight; stage 2: weighted product; then accumulate
      v1     <= (state == S_RUN);
      h1     <= hcnt;
      m1     <= mute_now;
      v2     <= v1 && !m1;
      prod_q <= prod_d;
      if (v2) acc <= acc + ACC_W'(prod_q);
      if (state == S_RUN) begin
        phase[hcnt] <= phase[hcnt] + inc[PHASE_W-1:0];
        inc         <= inc + INC_W'(freq_l);
        hcnt        <= hcnt + HW'(1);
      end
      if (strobe_ok) begin
        freq_l <= freq;
        gain_l <= gain;
        inc    <= INC_W'(freq);
        hcnt   <= '0;
        acc    <= '0;
      end
      if (state == S_DONE) out <= sat_out;
    end
  end
endmodule

// File: tb/tb_wavetable_additive_synth.sv
// tb/tb_wavetable_additive_synth.sv - self-checking bench for wavetable_additive_synth against a per-sample arithmetic model
`timescale 1ns/1ps
module tb_wavetable_additive_synth;
  localparam int PHASE_W  = 24;
  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 16;
  localparam int NUM_HARM = 8;
  localparam int GAIN_W   = 8;
  localparam int DEPTH    = 1 << ADDR_W;
  localparam int LAT      = NUM_HARM + 4;

  logic                        Clk = 1'b0;
  logic                        Reset_n = 1'b0;
  logic                        CS = 1'b0;
  logic                        sample_Clk = 1'b0;
  logic [PHASE_W-1:0]          freq = '0;
  logic [NUM_HARM*GAIN_W-1:0]  gain = '0;
  logic signed [DATA_W-1:0]    out;
  logic                        out_valid, busy, overrun;

  int     total = 0;
  int     bad = 0;
  int     tbl [DEPTH];
  longint mphase [NUM_HARM];

  always #5 Clk = ~Clk;

  wavetable_additive_synth #(
    .PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_HARM(NUM_HARM),
    .GAIN_W(GAIN_W), .LOAD_TABLE(1'b0)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .CS(CS), .sample_Clk(sample_Clk), .freq(freq),
    .gain(gain), .out(out), .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_ramp();
    for (int a = 0; a < DEPTH; a++) begin
      tbl[a] = a;
      dut.rom[a] = DATA_W'(a);
    end
  endtask

  task automatic load_const(input logic signed [DATA_W-1:0] v);
    for (int a = 0; a < DEPTH; a++) begin
      tbl[a] = v;
      dut.rom[a] = v;
    end
  endtask

  task automatic load_random();
    logic signed [DATA_W-1:0] r;
    for (int a = 0; a < DEPTH; a++) begin
      r = DATA_W'($urandom);
      tbl[a] = r;
      dut.rom[a] = r;
    end
  endtask

  task automatic model_reset();
    for (int h = 0; h < NUM_HARM; h++) mphase[h] = 0;
  endtask

  // sum of table[phase_h] * gain_h over harmonics, floor-scaled and clamped; phases advance by (h+1)*freq
  function automatic longint model_sample(input logic [PHASE_W-1:0] f, input logic [NUM_HARM*GAIN_W-1:0] g);
    longint sum = 0;
    longint sh, incv, gv;
    int     addr;
    bit     mute;
    for (int h = 0; h < NUM_HARM; h++) begin
      addr = int'(mphase[h] >> (PHASE_W - ADDR_W));
      incv = longint'(h + 1) * longint'(f);
      gv   = longint'(g[h*GAIN_W +: GAIN_W]);
      mute = 1'b0;
`ifdef NYQUIST_MUTE_EN
      mute = (incv >= (longint'(1) << (PHASE_W - 1)));
`endif
      if (!mute) sum += longint'(tbl[addr]) * gv;
      mphase[h] = (mphase[h] + incv) % (longint'(1) << PHASE_W);
    end
    sh = sum >>> GAIN_W;
    if (sh > 32767) sh = 32767;
    if (sh < -32768) sh = -32768;
    return sh;
  endfunction

  task automatic cs_pulse();
    CS = 1'b0;
    tick();
    CS = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic do_sample(input string tag, input logic [PHASE_W-1:0] f,
                           input logic [NUM_HARM*GAIN_W-1:0] g, input bit scramble);
    longint exp;
    int     n;
    freq = f;
    gain = g;
    sample_Clk = 1'b1;
    exp = model_sample(f, g);
    tick();
    sample_Clk = 1'b0;
    if (scramble) begin
      freq = PHASE_W'($urandom);
      gain = {$urandom, $urandom};
    end
    n = 1;
    check({tag, "_busy_on"}, busy, 1);
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, LAT);
    check({tag, "_out"}, out, exp);
    tick();
    check({tag, "_busy_off"}, busy, 0);
  endtask

  initial begin
    int n, pulses;
    longint exp;
    logic [PHASE_W-1:0] f;
    logic [NUM_HARM*GAIN_W-1:0] g;

    model_reset();
    load_ramp();
    tick();
    tick();
    check("rst_out", out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    Reset_n = 1'b1;
    CS = 1'b1;
    tick();

    g = '0;
    g[7:0] = 8'h80;
    for (int i = 0; i < 5; i++) do_sample($sformatf("ramp%0d", i), 24'h001000, g, 1'b0);

    cs_pulse();
    for (int i = 0; i < 3; i++) do_sample($sformatf("wrap%0d", i), 24'hFFF000, g, 1'b0);

    load_const(16'sh7FFF);
    do_sample("sat_hi", 24'h012345, {NUM_HARM{8'hFF}}, 1'b0);
    load_const(-16'sh8000);
    do_sample("sat_lo", 24'h054321, {NUM_HARM{8'hFF}}, 1'b0);

    load_ramp();
    cs_pulse();
    freq = 24'h003000;
    gain = g;
    exp = model_sample(freq, g);
    sample_Clk = 1'b1;
    tick();
    sample_Clk = 1'b0;
    n = 1;
    check("ovr_before", overrun, 0);
    tick(); tick();
    n = 3;
    sample_Clk = 1'b1;
    tick();
    sample_Clk = 1'b0;
    n = 4;
    check("ovr_set", overrun, 1);
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check("ovr_latency", n, LAT);
    check("ovr_out", out, exp);
    tick();
    check("ovr_busy_off", busy, 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    check("ovr_no_extra_valid", pulses, 0);
    check("ovr_sticky", overrun, 1);
    cs_pulse();
    check("ovr_cleared_by_cs", overrun, 0);

    load_random();
    f = PHASE_W'($urandom);
    g = {$urandom, $urandom};
    do_sample("pre_abort0", f, g, 1'b1);
    do_sample("pre_abort1", f, g, 1'b1);
    freq = f;
    gain = g;
    sample_Clk = 1'b1;
    tick();
    sample_Clk = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    CS = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) pulses++;
      sample_Clk = (i == 3);
    end
    sample_Clk = 1'b0;
    check("abort_no_valid", pulses, 0);
    check("abort_out", out, 0);
    check("abort_busy", busy, 0);
    CS = 1'b1;
    tick();
    model_reset();
    for (int i = 0; i < 3; i++) do_sample($sformatf("post_abort%0d", i), f, g, 1'b1);

    for (int i = 0; i < 6; i++) begin
      f = PHASE_W'($urandom);
      g = {$urandom, $urandom};
      do_sample($sformatf("rand%0d", i), f, g, 1'b1);
    end

    load_ramp();
    cs_pulse();
    g = '0;
    g[7:0] = 8'h80;
    g[15:8] = 8'h80;
    for (int i = 0; i < 3; i++) do_sample($sformatf("nyq%0d", i), 24'h400000, g, 1'b0);

    freq = 24'h400000;
    gain = g;
    sample_Clk = 1'b1;
    tick();
    sample_Clk = 1'b0;
    tick();
    sample_Clk = 1'b1;
    tick();
    sample_Clk = 1'b0;
    check("arst_pre_overrun", overrun, 1);
    #2;
    Reset_n = 1'b0;
    #1;
    check("arst_out", out, 0);
    check("arst_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_overrun", overrun, 0);
    tick();
    Reset_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
